// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared definitions for the PS/2 host-side blocks.
//   tx_state_t         : host transmit FSM encoding
//   FRAME_LEN          : device clock falling edges per host->device frame
//   FILT_LEN           : length of the PS/2 clock glitch filter
//   *_DEF              : default RTS hold and watchdog limits (100 MHz clk)
//   odd_parity()       : parity bit that makes the 9-bit payload odd
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RTS,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_ACK
    } tx_state_t;

    localparam int FRAME_LEN          = 11;
    localparam int FILT_LEN           = 8;
    localparam int PAYLOAD_BITS       = 9;        // 8 data bits + parity
    localparam int RTS_CYCLES_DEF     = 10000;    // 100 us
    localparam int TIMEOUT_CYCLES_DEF = 2000000;  // 20 ms

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_tx_if.sv
// ps2_tx_if -- host-side request/status bundle of the PS/2 transmitter.
//   wr_ps2       : one-cycle request to send din
//   din          : command byte
//   tx_idle      : transmitter ready for a request
//   tx_done_tick : frame acknowledged by the device
//   tx_err_tick  : frame aborted by the watchdog
// master = requester, slave = ps2_tx.
interface ps2_tx_if;
    logic       wr_ps2;
    logic [7:0] din;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       tx_err_tick;

    modport master (output wr_ps2, din,
                    input  tx_idle, tx_done_tick, tx_err_tick);
    modport slave  (input  wr_ps2, din,
                    output tx_idle, tx_done_tick, tx_err_tick);
endinterface

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter -- debounce the raw PS/2 clock and flag its falling edges.
//   clk, reset : system clock, synchronous active-high reset
//   ps2c_in    : raw PS/2 clock line
//   fall_edge  : one-cycle pulse on each 1->0 step of the filtered clock
// The filtered level only changes after FILT_LEN identical samples, so
// short glitches never produce an edge. Shared with the receiver.
module ps2_clk_filter
    import ps2_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic ps2c_in,
    output logic fall_edge
);

    logic [FILT_LEN-1:0] sr_q, sr_d;
    logic                filt_q, filt_d;

    always_comb begin
        sr_d   = {ps2c_in, sr_q[FILT_LEN-1:1]};
        filt_d = filt_q;
        if (&sr_q)
            filt_d = 1'b1;
        else if (~|sr_q)
            filt_d = 1'b0;
    end

    assign fall_edge = filt_q & ~filt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q   <= '1;
            filt_q <= 1'b1;
        end else begin
            sr_q   <= sr_d;
            filt_q <= filt_d;
        end
    end

endmodule

// File: rtl/ps2_tx.sv
// ps2_tx -- PS/2 host-to-device command transmitter.
//   clk, reset   : system clock, synchronous active-high reset
//   host         : ps2_tx_if.slave (wr_ps2/din in, tx_idle/done/err out)
//   ps2c_in      : sampled PS/2 clock line
//   ps2d_in      : sampled PS/2 data line (ack level is not checked)
//   ps2c_oe      : 1 pulls the PS/2 clock low
//   ps2d_oe      : 1 pulls the PS/2 data low
// Frame: hold clock low for RTS_CYCLES, then drive start, d0..d7, odd
// parity and release for stop, each bit changing on a device falling
// edge. The 11th falling edge is the device's ack edge; the one-cycle ack
// state then reports completion. A watchdog aborts if any device edge is
// more than TIMEOUT_CYCLES late.
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int RTS_CYCLES     = RTS_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic     clk,
    input  logic     reset,
    ps2_tx_if.slave  host,
    input  logic     ps2c_in,
    input  logic     ps2d_in,
    output logic     ps2c_oe,
    output logic     ps2d_oe
);

    localparam int CNT_MAX = (RTS_CYCLES > TIMEOUT_CYCLES) ? RTS_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    tx_state_t                 state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;        // RTS timer, then watchdog
    logic [3:0]                nbit_q, nbit_d;
    logic [PAYLOAD_BITS-1:0]   sh_q, sh_d;
    logic                      c_oe_q, c_oe_d;
    logic                      d_oe_q, d_oe_d;
    logic                      idle_q, idle_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
    logic                      fall_edge;
    logic                      ps2d_unused;

    assign ps2d_unused = ps2d_in;

    ps2_clk_filter u_filt (
        .clk       (clk),
        .reset     (reset),
        .ps2c_in   (ps2c_in),
        .fall_edge (fall_edge)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nbit_d  = nbit_q;
        sh_d    = sh_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A request arriving alongside a done/err tick is dropped.
                if (host.wr_ps2 && !done_q && !err_q) begin
                    sh_d    = {odd_parity(host.din), host.din};
                    cnt_d   = '0;
                    state_d = ST_RTS;
                end
            end
            ST_RTS: begin
                if (cnt_q == CW'(RTS_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_START;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ACK: begin
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                // START / DATA / STOP: advance on device edges, else watchdog.
                if (fall_edge) begin
                    cnt_d = '0;
                    if (state_q == ST_START) begin
                        nbit_d  = '0;
                        state_d = ST_DATA;
                    end else if (state_q == ST_DATA) begin
                        if (nbit_q == 4'(PAYLOAD_BITS - 1)) begin
                            state_d = ST_STOP;
                        end else begin
                            nbit_d = nbit_q + 1'b1;
                            sh_d   = sh_q >> 1;
                        end
                    end else begin
                        state_d = ST_ACK;
                    end
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase

        // Outputs are decoded from the next state so they register with it.
        c_oe_d = (state_d == ST_RTS);
        d_oe_d = (state_d == ST_START) || ((state_d == ST_DATA) && !sh_d[0]);
        idle_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            nbit_q  <= '0;
            sh_q    <= '0;
            c_oe_q  <= 1'b0;
            d_oe_q  <= 1'b0;
            idle_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nbit_q  <= nbit_d;
            sh_q    <= sh_d;
            c_oe_q  <= c_oe_d;
            d_oe_q  <= d_oe_d;
            idle_q  <= idle_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign ps2c_oe           = c_oe_q;
    assign ps2d_oe           = d_oe_q;
    assign host.tx_idle      = idle_q;
    assign host.tx_done_tick = done_q;
    assign host.tx_err_tick  = err_q;

endmodule
